// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Bundles the fetch stage's redirect, instruction-memory and
//               decode-side handshake signals. The master modport is the
//               fetch unit; the slave modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();
    logic              pcwrite;
    logic [ADDR_W-1:0] pc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] currpc;
    logic [ADDR_W-1:0] newpc;

    modport master (
        input  pcwrite, pc, mem_rvalid, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, ir, currpc, newpc
    );

    modport slave (
        output pcwrite, pc, mem_rvalid, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, ir, currpc, newpc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Keeps its own fetch PC, issues one
//               outstanding word request at a time to a variable-latency
//               memory, and queues {instr, pc} for decode. A redirect flushes
//               the queue and discards any response still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int PC_STEP   = 2,
    parameter int RESET_PC  = 0,
    parameter int BUF_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    fetch_if.master   bus
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [CNT_W-1:0]  c_depth    = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0]  c_last     = PTR_W'(BUF_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_step     = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);

    // FETCH: idle; WAIT: live request out; DRAIN: stale request out
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fpc;
    logic [DATA_W-1:0] r_instr [BUF_DEPTH];
    logic [ADDR_W-1:0] r_pcq   [BUF_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic w_req;
    logic w_push;
    logic w_pop;
    logic w_valid;

    // A request only goes out when a queue slot is guaranteed for its data,
    // so a push can never overflow. Held low during reset.
    assign w_req   = !rst && (r_state == S_FETCH) && (r_count < c_depth) && !bus.pcwrite;
    assign w_push  = (r_state == S_WAIT) && bus.mem_rvalid && !bus.pcwrite;
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.out_ready;

    assign bus.mem_req   = w_req;
    assign bus.mem_addr  = r_fpc;
    assign bus.out_valid = w_valid;
    assign bus.ir        = w_valid ? r_instr[r_rptr] : '0;
    assign bus.currpc    = w_valid ? r_pcq[r_rptr] : '0;
    assign bus.newpc     = w_valid ? (r_pcq[r_rptr] + c_step) : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a response always closes the outstanding request; a
    // redirect without a response turns the live request stale.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_req) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = S_FETCH;
                end else if (bus.pcwrite) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Fetch PC: redirect wins, otherwise advance once per accepted response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpc <= c_reset_pc;
        end else if (bus.pcwrite) begin
            r_fpc <= bus.pc;
        end else if (w_push) begin
            r_fpc <= r_fpc + c_step;
        end
    end

    // Queue occupancy and pointers; a redirect empties the queue outright
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else if (bus.pcwrite) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Queue storage; contents are only visible through the valid-gated head
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wptr] <= bus.mem_rdata;
            r_pcq[r_wptr]   <= r_fpc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with a variable-latency
//               memory model returning addr ^ 0xA5A5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    fetch_unit #(
        .DATA_W    (16),
        .ADDR_W    (16),
        .PC_STEP   (2),
        .RESET_PC  (16'h0100),
        .BUF_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks    = 0;
    int          failures  = 0;
    logic [15:0] sb_q[$];
    int          cyc       = 0;
    int          rv_cyc    = -100;
    int          last_pop  = -100;
    bit          rate_on   = 1'b0;
    int          lat       = 1;
    bit          quiet     = 1'b0;
    bit          mbusy     = 1'b0;
    int          mcnt      = 0;
    logic [15:0] maddr     = '0;
    logic        req_s     = 1'b0;
    logic [15:0] addr_s    = '0;
    logic [15:0] exp_pc;
    logic [15:0] exp_np;
    logic [15:0] exp_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: got no mem_req within %0d cycles expected a request", name, bound);
        end
    endtask

    task automatic wait_empty(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got %0d outputs still pending expected 0", name, sb_q.size());
        end
    endtask

    task automatic do_reset(input int new_lat);
        quiet = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_mem_req",   32'(bus.mem_req),   32'h0);
        chk("midreset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("midreset_ir",        32'(bus.ir),        32'h0);
        chk("midreset_currpc",    32'(bus.currpc),    32'h0);
        chk("midreset_newpc",     32'(bus.newpc),     32'h0);
        sb_q.delete();
        lat = new_lat;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        quiet = 1'b0;
        @(negedge clk);
        chk("release_mem_req",  32'(bus.mem_req),  32'h1);
        chk("release_mem_addr", 32'(bus.mem_addr), 32'h0100);
    endtask

    // Latch the request seen just before each rising edge
    always @(negedge clk) begin
        req_s  = bus.mem_req;
        addr_s = bus.mem_addr;
    end

    // Memory model: answers each request `lat` cycles later
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.mem_rvalid = 1'b0;
            if (quiet || rst) begin
                mbusy = 1'b0;
            end else begin
                if (req_s) begin
                    mbusy = 1'b1;
                    mcnt  = lat;
                    maddr = addr_s;
                end else if (mbusy) begin
                    mcnt--;
                end
                if (mbusy && mcnt == 1) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = maddr ^ 16'hA5A5;
                    mbusy          = 1'b0;
                    rv_cyc         = cyc;
                end
            end
        end
    end

    // Monitor: compare every accepted output against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got currpc 0x%0h expected no output", bus.currpc);
            end else begin
                exp_pc = sb_q.pop_front();
                exp_np = exp_pc + 16'd2;
                exp_ir = exp_pc ^ 16'hA5A5;
                chk("out_ir",     32'(bus.ir),     32'(exp_ir));
                chk("out_currpc", 32'(bus.currpc), 32'(exp_pc));
                chk("out_newpc",  32'(bus.newpc),  32'(exp_np));
                if (rate_on && exp_pc >= 16'h0106 && exp_pc <= 16'h010E) begin
                    chk("stream_gap", 32'(cyc - last_pop), 32'd2);
                end
            end
            last_pop = cyc;
        end
    end

    // Stimulus
    initial begin
        int          nreq;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] p;

        bus.pcwrite   = 1'b0;
        bus.pc        = '0;
        bus.out_ready = 1'b0;
        lat           = 1;

        #2;
        chk("reset_mem_req",   32'(bus.mem_req),   32'h0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_ir",        32'(bus.ir),        32'h0);
        chk("reset_currpc",    32'(bus.currpc),    32'h0);
        chk("reset_newpc",     32'(bus.newpc),     32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_mem_req",  32'(bus.mem_req),  32'h1);
        chk("first_mem_addr", 32'(bus.mem_addr), 32'h0100);

        // Backpressure: queue of two fills, then requests stop
        nreq = 0;
        a0   = '0;
        a1   = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.mem_req) begin
                if (nreq == 0) a0 = bus.mem_addr;
                else if (nreq == 1) a1 = bus.mem_addr;
                nreq++;
            end
            @(negedge clk);
        end
        chk("bp_req_count", 32'(nreq), 32'd2);
        chk("bp_addr0",     32'(a0),   32'h0100);
        chk("bp_addr1",     32'(a1),   32'h0102);
        chk("bp_stalled",   32'(bus.mem_req), 32'h0);

        // Release backpressure and stream
        p = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(p);
            p = p + 16'd2;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_req("resume_req", 10);
        chk("resume_addr", 32'(bus.mem_addr), 32'h0104);
        rate_on = 1'b1;
        wait_empty("stream_drain", 80);
        rate_on = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Redirect while a 3-cycle request is outstanding
        do_reset(3);
        wait_req("redir_wait_req", 10);
        chk("redir_wait_addr", 32'(bus.mem_addr), 32'h0102);
        @(posedge clk);
        #1;
        bus.pcwrite = 1'b1;
        bus.pc      = 16'h0400;
        @(negedge clk);
        chk("redir_hold_valid", 32'(bus.out_valid), 32'h1);
        chk("redir_no_req",     32'(bus.mem_req),   32'h0);
        @(posedge clk);
        #1;
        bus.pcwrite = 1'b0;
        @(negedge clk);
        chk("redir_flushed", 32'(bus.out_valid), 32'h0);
        wait_req("redir_new_req", 10);
        chk("redir_new_addr",  32'(bus.mem_addr), 32'h0400);
        chk("redir_new_cycle", 32'(cyc),          32'(rv_cyc + 1));
        sb_q.push_back(16'h0400);
        sb_q.push_back(16'h0402);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_empty("redir_drain", 40);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Redirect coinciding with a response and a pop
        do_reset(2);
        wait_req("sim_wait_req", 10);
        chk("sim_wait_addr", 32'(bus.mem_addr), 32'h0102);
        sb_q.push_back(16'h0100);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.pcwrite   = 1'b1;
        bus.pc        = 16'h0200;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("sim_head_valid", 32'(bus.out_valid), 32'h1);
        @(posedge clk);
        #1;
        bus.pcwrite   = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("sim_flushed",  32'(bus.out_valid), 32'h0);
        chk("sim_req",      32'(bus.mem_req),   32'h1);
        chk("sim_req_addr", 32'(bus.mem_addr),  32'h0200);

        // Wrap: redirect to the top of the address space
        @(posedge clk);
        #1;
        bus.pcwrite = 1'b1;
        bus.pc      = 16'hFFFE;
        @(posedge clk);
        #1;
        bus.pcwrite   = 1'b0;
        bus.out_ready = 1'b1;
        sb_q.push_back(16'hFFFE);
        sb_q.push_back(16'h0000);
        wait_req("wrap_req0", 10);
        chk("wrap_addr0", 32'(bus.mem_addr), 32'hFFFE);
        wait_req("wrap_req1", 10);
        chk("wrap_addr1", 32'(bus.mem_addr), 32'h0000);
        wait_empty("wrap_drain", 40);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch stage sitting between the PC logic and decode. It runs its own fetch PC and issues word requests to an instruction memory whose response latency is variable (one or more cycles). Fetched instructions go into a small in-order queue, tagged with their PC and PC+step. Decode reads them through a valid/ready handshake, and a redirect (`pcwrite`/`pc`) flushes the queue and discards any response still in flight.

## Interface
- `DATA_W`, 16, instruction width in bits.
- `ADDR_W`, 16, PC/address width in bits.
- `PC_STEP`, 2, PC increment per instruction.
- `RESET_PC`, 0, fetch PC loaded on reset.
- `BUF_DEPTH`, 2, queue entries (≥1).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `pcwrite`  in  1  redirect strobe.
- `pc`  in  ADDR_W  redirect target, sampled when `pcwrite`=1.
- `mem_req`  out  1  read request; memory always accepts it in the same cycle.
- `mem_addr`  out  ADDR_W  request address; equals the fetch PC.
- `mem_rvalid`  in  1  response valid; at earliest the cycle after `mem_req`.
- `mem_rdata`  in  DATA_W  response instruction.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  decode accepts head.
- `ir`  out  DATA_W  head instruction; 0 when `out_valid`=0.
- `currpc`  out  ADDR_W  head PC; 0 when `out_valid`=0.
- `newpc`  out  ADDR_W  head PC + `PC_STEP` mod 2^ADDR_W; 0 when `out_valid`=0.

## Operation
- At most one request outstanding.
- The queue is a circular FIFO of {instr, pc} with count 0..BUF_DEPTH.
- States:
  - **FETCH**: no request outstanding.
    - `mem_req`=1 when count < BUF_DEPTH and `pcwrite`=0; then go to WAIT.
    - Otherwise stay in FETCH.
  - **WAIT**: request outstanding.
    - On `mem_rvalid` with no redirect: push {`mem_rdata`, fetch PC}, fetch PC += `PC_STEP`, go to FETCH.
  - **DRAIN**: a request is outstanding but stale.
    - On `mem_rvalid`: drop the data, go to FETCH.
- Redirect (`pcwrite`=1) in any state:
  - Fetch PC ← `pc`.
  - Queue count ← 0, overriding any push or pop in the same cycle.
  - In FETCH: `mem_req` is suppressed that cycle.
  - In WAIT with `mem_rvalid`=1 the same cycle: the response is dropped and the state goes to FETCH.
  - In WAIT with `mem_rvalid`=0: go to DRAIN.
  - In DRAIN: stay in DRAIN and keep the new target.
- Pop occurs when `out_valid && out_ready`. A push and a pop in the same cycle leave count unchanged; a push into a full queue with a simultaneous pop is legal.
- The request gate (count < BUF_DEPTH in FETCH) ensures no push ever overflows the queue.
- Arithmetic: fetch PC and `newpc` wrap modulo 2^ADDR_W.
- `mem_rvalid` in FETCH state is a protocol error and is ignored.
- Reset values:
  - state=FETCH, fetch PC=`RESET_PC`, count=0, pointers=0.
  - `out_valid`=0; `ir`/`currpc`/`newpc`=0.
  - `mem_req`=0 while `rst`=1.

## Timing
- `mem_req`/`mem_addr` are combinational from state, count and `pcwrite`. All other outputs are combinational from queue head and count only; there is no path from `mem_rdata` to `ir`.
- Latency from `mem_rvalid` (push edge) to `out_valid`=1 is the next cycle.
- Steady-state rate with 1-cycle memory latency: one request every 2 cycles, i.e. throughput 1 instruction per 2 cycles.
- Redirect in cycle N: the first request to `pc` is issued in cycle N+1 if not in WAIT/DRAIN; otherwise it is issued in the cycle after the stale response returns.
- Reset asserted mid-WAIT or mid-DRAIN: the outstanding response is forgotten, and any `mem_rvalid` arriving after reset release is ignored as a FETCH-state error. The environment must not deliver a late response; the bench quiesces memory around reset.

## Test plan
- **Reset:** assert `rst` async mid-cycle with `RESET_PC`=0x0100 → outputs 0 immediately. After release, `mem_req`=1 with `mem_addr`=0x0100.
- **Streaming:** 1-cycle memory, `out_ready`=1, data = addr XOR 0xA5A5 → out sequence `currpc` 0x0100, 0x0102, 0x0104…, each `newpc`=`currpc`+2, one valid every 2 cycles.
- **Backpressure:** `out_ready`=0 with BUF_DEPTH=2 → exactly 2 requests issued, then `mem_req` stays 0. Raising `out_ready` pops 0x0100 first and requests resume at 0x0104.
- **Redirect in WAIT:** 3-cycle memory, `pcwrite`=1 with `pc`=0x0400 one cycle after the request to 0x0102 → that response is dropped, and the next `mem_addr`=0x0400 is issued the cycle after it returns. The first output is `currpc`=0x0400 and the queue was emptied at the redirect.
- **Redirect simultaneous with `mem_rvalid` and pop:** `pcwrite`=1 with `pc`=0x0200 → count=0 next cycle, response dropped, `mem_req` to 0x0200 issued next cycle.
- **Wrap:** redirect to 0xFFFE → `currpc`=0xFFFE with `newpc`=0x0000, next fetch `mem_addr`=0x0000.
